// File: rtl/vga_pattern_pkg.sv
// Shared mode encodings, 3-bit colour codes and channel expansion for the VGA pattern generator.
// Pure definitions, no state; no latency or flow control involved.
package vga_pattern_pkg;

    localparam logic [1:0] MODE_SPLIT = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_BOX   = 2'd3;

    // Widest colour channel the expansion function can serve.
    localparam int CHAN_MAX_W = 16;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } color_code_t;

    localparam color_code_t CC_BLACK   = 3'b000;
    localparam color_code_t CC_BLUE    = 3'b001;
    localparam color_code_t CC_GREEN   = 3'b010;
    localparam color_code_t CC_CYAN    = 3'b011;
    localparam color_code_t CC_RED     = 3'b100;
    localparam color_code_t CC_MAGENTA = 3'b101;
    localparam color_code_t CC_YELLOW  = 3'b110;
    localparam color_code_t CC_WHITE   = 3'b111;

    function automatic color_code_t bar_code(input logic [3:0] idx);
        color_code_t c;
        case (idx)
            4'd0:    c = CC_WHITE;
            4'd1:    c = CC_YELLOW;
            4'd2:    c = CC_CYAN;
            4'd3:    c = CC_GREEN;
            4'd4:    c = CC_MAGENTA;
            4'd5:    c = CC_RED;
            4'd6:    c = CC_BLUE;
            default: c = CC_BLACK;
        endcase
        return c;
    endfunction

    // Full intensity means every channel bit set; callers cast down to their width.
    function automatic logic [CHAN_MAX_W-1:0] chan_fill(input logic on);
        return {CHAN_MAX_W{on}};
    endfunction

endpackage

// File: rtl/vga_box_tracker.sv
// Bouncing-box position state for both axes, advanced once per enabled frame end.
// Position updates on the cycle after step_en; holds otherwise.
// No backpressure: step_en is a single-cycle event.
module vga_box_tracker
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 11,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 2
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              step_en,
    output logic [ADDR_W-1:0] box_x,
    output logic [ADDR_W-1:0] box_y
);

    localparam logic [ADDR_W:0]   STEP_W = (ADDR_W+1)'(BOX_STEP);
    localparam logic [ADDR_W:0]   SIZE_W = (ADDR_W+1)'(BOX_SIZE);
    localparam logic [ADDR_W:0]   H_LIM  = (ADDR_W+1)'(H_ACTIVE);
    localparam logic [ADDR_W:0]   V_LIM  = (ADDR_W+1)'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] STEP_N = ADDR_W'(BOX_STEP);

    logic            dir_x_neg;
    logic            dir_y_neg;
    logic [ADDR_W:0] nx;
    logic [ADDR_W:0] ny;

    // Returns {next direction (1 = decreasing), next position}; limit checks
    // run one bit wider so pos+step+size cannot wrap.
    function automatic logic [ADDR_W:0] axis_next(input logic [ADDR_W-1:0] pos,
                                                  input logic              neg,
                                                  input logic [ADDR_W:0]   limit);
        logic [ADDR_W:0] res;
        if (!neg) begin
            if ({1'b0, pos} + STEP_W + SIZE_W <= limit)
                res = {1'b0, pos + STEP_N};
            else
                res = {1'b1, pos - STEP_N};
        end else begin
            if ({1'b0, pos} >= STEP_W)
                res = {1'b1, pos - STEP_N};
            else
                res = {1'b0, pos + STEP_N};
        end
        return res;
    endfunction

    assign nx = axis_next(box_x, dir_x_neg, H_LIM);
    assign ny = axis_next(box_y, dir_y_neg, V_LIM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            box_x     <= '0;
            box_y     <= '0;
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
        end else if (step_en) begin
            {dir_x_neg, box_x} <= nx;
            {dir_y_neg, box_y} <= ny;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Mode-selectable VGA test pattern generator (split, bars, checker, bouncing box) to RGB565 pins.
// One cycle from coordinates to registered RGB; mode and animation change only at frame end.
// No backpressure: Ready_Sig qualifies each pixel, blanked pixels are driven black.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 11,
    parameter int R_W         = 5,
    parameter int G_W         = 6,
    parameter int B_W         = 5,
    parameter int SPLIT_ROW   = 100,
    parameter int BAR_W       = 80,
    parameter int CHECK_SHIFT = 5,
    parameter int BOX_SIZE    = 64,
    parameter int BOX_STEP    = 2
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Ready_Sig,
    input  logic [ADDR_W-1:0] Column_Addr_Sig,
    input  logic [ADDR_W-1:0] Row_Addr_Sig,
    input  logic [1:0]        Mode_Sig,
    output logic [R_W-1:0]    Red_Sig,
    output logic [G_W-1:0]    Green_Sig,
    output logic [B_W-1:0]    Blue_Sig,
    output logic [7:0]        Frame_Cnt_Sig
);

    localparam logic [ADDR_W:0]   H_LIM     = (ADDR_W+1)'(H_ACTIVE);
    localparam logic [ADDR_W:0]   V_LIM     = (ADDR_W+1)'(V_ACTIVE);
    localparam logic [ADDR_W:0]   BOX_SZ    = (ADDR_W+1)'(BOX_SIZE);
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] SPLIT_LIM = ADDR_W'(SPLIT_ROW);
    localparam logic [ADDR_W-1:0] BAR_LAST  = ADDR_W'(BAR_W - 1);
    localparam logic [3:0]        BAR_END   = 4'd8;

    logic [1:0]        mode_q;
    logic [3:0]        bar_idx;
    logic [ADDR_W-1:0] bar_px;
    logic [ADDR_W-1:0] box_x;
    logic [ADDR_W-1:0] box_y;
    logic              fe;
    logic              in_view;
    logic              col_zero;
    logic              in_box;
    logic [ADDR_W:0]   col_w;
    logic [ADDR_W:0]   row_w;
    color_code_t       pix_code;

    assign col_w    = {1'b0, Column_Addr_Sig};
    assign row_w    = {1'b0, Row_Addr_Sig};
    assign col_zero = (Column_Addr_Sig == '0);
    assign fe       = Ready_Sig && (Column_Addr_Sig == COL_LAST) && (Row_Addr_Sig == ROW_LAST);
    assign in_view  = (col_w < H_LIM) && (row_w < V_LIM);
    assign in_box   = (col_w >= {1'b0, box_x}) && (col_w < {1'b0, box_x} + BOX_SZ) &&
                      (row_w >= {1'b0, box_y}) && (row_w < {1'b0, box_y} + BOX_SZ);

    vga_box_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .CLK     (CLK),
        .RST     (RST),
        .step_en (fe && (mode_q == MODE_BOX)),
        .box_x   (box_x),
        .box_y   (box_y)
    );

    always_comb begin
        pix_code = CC_BLACK;
        case (mode_q)
            MODE_SPLIT: if (Row_Addr_Sig < SPLIT_LIM) pix_code = CC_WHITE;
            // Column 0 is where the bar counters restart, so it is forced to bar 0.
            MODE_BARS:  pix_code = bar_code(col_zero ? 4'd0 : bar_idx);
            MODE_CHECK: if (Column_Addr_Sig[CHECK_SHIFT] ^ Row_Addr_Sig[CHECK_SHIFT]) pix_code = CC_WHITE;
            default:    pix_code = in_box ? CC_RED : CC_BLUE;
        endcase
        if (!Ready_Sig || !in_view)
            pix_code = CC_BLACK;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Red_Sig       <= '0;
            Green_Sig     <= '0;
            Blue_Sig      <= '0;
            mode_q        <= MODE_SPLIT;
            Frame_Cnt_Sig <= 8'd0;
            bar_idx       <= 4'd0;
            bar_px        <= '0;
        end else begin
            Red_Sig   <= R_W'(chan_fill(pix_code.r));
            Green_Sig <= G_W'(chan_fill(pix_code.g));
            Blue_Sig  <= B_W'(chan_fill(pix_code.b));

            if (fe) begin
                mode_q        <= Mode_Sig;
                Frame_Cnt_Sig <= Frame_Cnt_Sig + 8'd1;
            end

            if (Ready_Sig) begin
                if (col_zero) begin
                    bar_idx <= 4'd0;
                    bar_px  <= ADDR_W'(1);
                end else if (bar_px == BAR_LAST) begin
                    bar_px <= '0;
                    if (bar_idx != BAR_END)
                        bar_idx <= bar_idx + 4'd1;
                end else begin
                    bar_px <= bar_px + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed, table-driven bench for vga_pattern_gen with hand-computed RGB565 expectations.
module tb_vga_pattern_gen;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Ready_Sig = 1'b0;
    logic [10:0] Column_Addr_Sig = '0;
    logic [10:0] Row_Addr_Sig = '0;
    logic [1:0]  Mode_Sig = 2'd0;
    logic [4:0]  Red_Sig;
    logic [5:0]  Green_Sig;
    logic [4:0]  Blue_Sig;
    logic [7:0]  Frame_Cnt_Sig;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_fc = 8'd0;
    logic [1:0]  cur_mode = 2'd0;

    typedef struct {
        logic [1:0]  mode;
        int          col;
        int          row;
        logic        rdy;
        logic [15:0] rgb;
    } vec_t;

    vec_t        vecs[14];
    int          bar_col[12];
    logic [15:0] bar_exp[12];

    vga_pattern_gen dut (
        .CLK             (CLK),
        .RST             (RST),
        .Ready_Sig       (Ready_Sig),
        .Column_Addr_Sig (Column_Addr_Sig),
        .Row_Addr_Sig    (Row_Addr_Sig),
        .Mode_Sig        (Mode_Sig),
        .Red_Sig         (Red_Sig),
        .Green_Sig       (Green_Sig),
        .Blue_Sig        (Blue_Sig),
        .Frame_Cnt_Sig   (Frame_Cnt_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic check_rgb(input string nm, input logic [15:0] want);
        logic [15:0] got;
        got = {Red_Sig, Green_Sig, Blue_Sig};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: rgb got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_fc(input string nm);
        total++;
        if (Frame_Cnt_Sig !== exp_fc) begin
            bad++;
            $display("FAIL %s: frame_cnt got %0d want %0d", nm, Frame_Cnt_Sig, exp_fc);
        end
    endtask

    // One pixel presented for exactly one rising edge, result checked at the next falling edge.
    task automatic px(input int c, input int r, input logic rdy, input logic [15:0] want, input string nm);
        @(negedge CLK);
        Column_Addr_Sig = 11'(c);
        Row_Addr_Sig    = 11'(r);
        Ready_Sig       = rdy;
        @(negedge CLK);
        check_rgb(nm, want);
        Ready_Sig = 1'b0;
        if (rdy && c == 639 && r == 479)
            exp_fc++;
    endtask

    task automatic frame_end();
        @(negedge CLK);
        Column_Addr_Sig = 11'd639;
        Row_Addr_Sig    = 11'd479;
        Ready_Sig       = 1'b1;
        @(negedge CLK);
        Ready_Sig = 1'b0;
        exp_fc++;
    endtask

    initial begin
        vecs[0]  = '{2'd0,   5,  99, 1'b1, WHITE};
        vecs[1]  = '{2'd0,   5, 100, 1'b1, BLACK};
        vecs[2]  = '{2'd0, 639,   0, 1'b1, WHITE};
        vecs[3]  = '{2'd0,   5,   5, 1'b0, BLACK};
        vecs[4]  = '{2'd0, 700,   5, 1'b1, BLACK};
        vecs[5]  = '{2'd0,   5, 480, 1'b1, BLACK};
        vecs[6]  = '{2'd2,   0,   0, 1'b1, BLACK};
        vecs[7]  = '{2'd2,  32,   0, 1'b1, WHITE};
        vecs[8]  = '{2'd2,  32,  32, 1'b1, BLACK};
        vecs[9]  = '{2'd2,  31,  31, 1'b1, BLACK};
        vecs[10] = '{2'd2,   0,  32, 1'b1, WHITE};
        vecs[11] = '{2'd2,  64,   0, 1'b1, BLACK};
        vecs[12] = '{2'd2, 639, 479, 1'b1, WHITE};
        vecs[13] = '{2'd2, 100, 479, 1'b0, BLACK};

        bar_col = '{0, 79, 80, 159, 160, 240, 320, 400, 480, 559, 560, 639};
        bar_exp = '{WHITE, WHITE, YELLOW, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLUE, BLACK, BLACK};

        // Reset state
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_rgb("reset_rgb", BLACK);
        check_fc("reset_fc");

        // Enter checkerboard, then reset for two cycles mid-frame on a white pixel
        Mode_Sig = 2'd2;
        frame_end();
        check_fc("fc_after_one");
        px(32, 0, 1'b1, WHITE, "pre_reset_white");
        @(negedge CLK);
        Column_Addr_Sig = 11'd32;
        Row_Addr_Sig    = 11'd0;
        Ready_Sig       = 1'b1;
        RST             = 1'b1;
        @(negedge CLK);
        exp_fc = 8'd0;
        check_rgb("mid_reset_rgb", BLACK);
        check_fc("mid_reset_fc");
        @(negedge CLK);
        RST       = 1'b0;
        Ready_Sig = 1'b0;
        cur_mode  = 2'd0;
        Mode_Sig  = 2'd0;

        // Table: split screen after reset (mode_q back to 0), then checkerboard
        for (int i = 0; i < 14; i++) begin
            Mode_Sig = vecs[i].mode;
            if (vecs[i].mode != cur_mode) begin
                frame_end();
                cur_mode = vecs[i].mode;
            end
            px(vecs[i].col, vecs[i].row, vecs[i].rdy, vecs[i].rgb, $sformatf("tbl%0d", i));
        end
        check_fc("fc_after_table");

        // Mode request mid-frame only takes effect after the frame end
        Mode_Sig = 2'd0;
        frame_end();
        Mode_Sig = 2'd1;
        px(5, 99, 1'b1, WHITE, "midframe_still_split");
        frame_end();
        for (int c = 0; c <= 640; c++) begin
            @(negedge CLK);
            if (c > 0)
                for (int k = 0; k < 12; k++)
                    if (bar_col[k] == c - 1)
                        check_rgb($sformatf("bar_col%0d", c - 1), bar_exp[k]);
            if (c < 640) begin
                Column_Addr_Sig = 11'(c);
                Row_Addr_Sig    = 11'd10;
                Ready_Sig       = 1'b1;
            end else begin
                Ready_Sig = 1'b0;
            end
        end
        check_fc("fc_after_bars");

        // Bouncing box: switch frame does not advance, next one moves to (2,2)
        Mode_Sig = 2'd3;
        frame_end();
        frame_end();
        px(1, 1, 1'b1, BLUE, "box1_11");
        px(2, 2, 1'b1, RED, "box1_22");
        px(65, 65, 1'b1, RED, "box1_6565");
        px(66, 66, 1'b1, BLUE, "box1_6666");

        // 288 advances: x=576 (right edge), y bounced at 416 back to 256
        repeat (287) frame_end();
        px(576, 256, 1'b1, RED, "box288_tl");
        px(575, 256, 1'b1, BLUE, "box288_left");
        px(639, 319, 1'b1, RED, "box288_br");
        px(639, 320, 1'b1, BLUE, "box288_below");

        // 289th advance reverses x to 574, y continues down to 254
        frame_end();
        px(574, 254, 1'b1, RED, "box289_tl");
        px(573, 254, 1'b1, BLUE, "box289_left");
        px(637, 317, 1'b1, RED, "box289_br");
        px(638, 317, 1'b1, BLUE, "box289_right");

        // Leaving mode 3: the leaving frame end still advances (572,252), then holds
        Mode_Sig = 2'd0;
        frame_end();
        frame_end();
        Mode_Sig = 2'd3;
        frame_end();
        px(572, 252, 1'b1, RED, "box_hold_tl");
        px(571, 252, 1'b1, BLUE, "box_hold_left");
        px(572, 252, 1'b0, BLACK, "not_ready_black");
        check_fc("fc_after_box");

        // Frame counter wrap
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST    = 1'b0;
        exp_fc = 8'd0;
        repeat (255) frame_end();
        check_fc("fc_255");
        total++;
        if (Frame_Cnt_Sig !== 8'd255) begin
            bad++;
            $display("FAIL fc_255_const: frame_cnt got %0d want 255", Frame_Cnt_Sig);
        end
        frame_end();
        check_fc("fc_wrap");
        total++;
        if (Frame_Cnt_Sig !== 8'd0) begin
            bad++;
            $display("FAIL fc_wrap_const: frame_cnt got %0d want 0", Frame_Cnt_Sig);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
